// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the I/D-cache main-memory arbiter.
package mem_bus_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_WAIT  = 2'd1,
        D_WAIT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Two-way round-robin pick: a lone requester wins, a tie goes to the
    // side that was not granted last.
    function automatic logic pick_grant(input logic ic_req,
                                        input logic dc_req,
                                        input logic last);
        if (ic_req && dc_req) begin
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (dc_req) begin
            return GRANT_D;
        end else begin
            return GRANT_I;
        end
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single main-memory port between the I-cache (read only)
// and the D-cache (read / write-back). One transaction at a time; the
// memory request and the returned line are registered, and the granted
// cache gets a one-cycle ready pulse, followed by a one-cycle release gap.
module mem_bus_arbiter #(
    parameter int ADDR_W = mem_bus_pkg::ADDR_W,
    parameter int DATA_W = mem_bus_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    import mem_bus_pkg::*;

    state_t state;
    logic   last_grant;
    logic   dc_pend;
    logic   grant;

    // Pending-request decode and round-robin choice for the IDLE state.
    always_comb begin
        dc_pend = dc_read | dc_write;
        grant   = pick_grant(ic_read, dc_pend, last_grant);
    end

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            ic_rdata   <= '0;
            ic_ready   <= 1'b0;
            dc_rdata   <= '0;
            dc_ready   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            ic_ready <= 1'b0;
            dc_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_read || dc_pend) begin
                        last_grant <= grant;
                        if (grant == GRANT_D) begin
                            // read+write together is treated as a write
                            mem_addr  <= dc_addr;
                            mem_wdata <= dc_wdata;
                            mem_write <= dc_write;
                            mem_read  <= ~dc_write;
                            state     <= D_WAIT;
                        end else begin
                            mem_addr  <= ic_addr;
                            mem_read  <= 1'b1;
                            mem_write <= 1'b0;
                            state     <= I_WAIT;
                        end
                    end
                end
                I_WAIT: begin
                    if (mem_ready) begin
                        mem_read <= 1'b0;
                        ic_rdata <= mem_rdata;
                        ic_ready <= 1'b1;
                        state    <= RELEASE;
                    end
                end
                D_WAIT: begin
                    if (mem_ready) begin
                        if (mem_read) begin
                            dc_rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        dc_ready  <= 1'b1;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single slow main-memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined CPU.
- Grants one requester at a time with round-robin tie-break and registers the memory request.
- Forwards the returned line plus a one-cycle ready pulse to the granted cache, which holds its request (stalls) until that pulse.
- Sits between the two caches and the memory model that the TestBed write-port monitor observes.

Parameters:
- ADDR_W, 28, memory line address width (word address >> 2).
- DATA_W, 128, cache-line width in bits.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- ic_read  input  1  I-cache line-read request, held until ic_ready
- ic_addr  input  ADDR_W  I-cache line address
- ic_rdata  output  DATA_W  returned line, registered
- ic_ready  output  1  one-cycle completion pulse to I-cache
- dc_read  input  1  D-cache line-read request, held until dc_ready
- dc_write  input  1  D-cache line-write (write-back) request, held until dc_ready
- dc_addr  input  ADDR_W  D-cache line address
- dc_wdata  input  DATA_W  write-back line
- dc_rdata  output  DATA_W  returned line, registered
- dc_ready  output  1  one-cycle completion pulse to D-cache
- mem_read  output  1  memory read strobe, held until mem_ready
- mem_write  output  1  memory write strobe, held until mem_ready
- mem_addr  output  ADDR_W  memory line address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, one or more cycles

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last_grant=I.
  - All outputs 0, including rdata buses.
  - Asserting rst mid-transaction aborts it: mem_read/mem_write are 0 after that edge and no ready pulse is issued.
- States: IDLE, I_WAIT, D_WAIT, RELEASE. All outputs registered.
- IDLE:
  - dc_pend = dc_read|dc_write.
  - Only ic_read → grant I. Only dc_pend → grant D.
  - Both pending → grant the side not equal to last_grant. After reset, D wins the first tie.
  - On grant: latch addr (and wdata for D); update last_grant.
  - Next cycle: mem_read=1 (I, or D read) or mem_write=1 (D write).
  - dc_read & dc_write both high is a protocol error; treat it as a write.
- I_WAIT / D_WAIT:
  - mem_addr, mem_wdata and the strobe are held constant.
  - On the edge where mem_ready=1: strobes go to 0.
  - For a read, mem_rdata is captured into the granted port's rdata.
  - The granted port's ready is 1 for exactly the next cycle; go to RELEASE.
  - Write: dc_rdata unchanged, dc_ready still pulses.
- RELEASE:
  - Exactly one cycle. Requests are ignored so the requester can drop its held req; then return to IDLE.
- Latency:
  - Request sampled at edge 0 → mem strobe high in cycle 1.
  - mem_ready sampled at edge k → ready high in cycle k+1.
  - Earliest next grant at edge k+2; earliest next strobe in cycle k+3.
- Boundary conditions:
  - mem_ready seen in IDLE or RELEASE is ignored.
  - A requester dropping its req mid-transaction does not cancel it: the transaction completes and the ready pulse is still issued.
  - A request edge arriving in the same cycle as another's completion waits for IDLE.
  - rdata buses hold their value until that port's next read completion.
  - No starvation: with both requesters continuously pending, grants alternate I,D,I,D….

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum (IDLE=2'd0, I_WAIT=2'd1, D_WAIT=2'd2, RELEASE=2'd3);
  - ADDR_W and DATA_W constants;
  - GRANT_I/GRANT_D encoding (1 bit).
- Sub-modules: none. The 2-way round-robin pick is a few lines inline.
- Memory latency model is bench-only.

Test Plan:
- Single I read:
  - Stimulus: ic_read=1, ic_addr=28'h0000010; memory asserts mem_ready after 4 cycles with mem_rdata=128'h…DEAD_BEEF.
  - Response: mem_read=1 from cycle 1 to 4, mem_addr=28'h10, ic_ready pulse in cycle 5, ic_rdata=…DEADBEEF, ic_read drop accepted.
- D write-back:
  - Stimulus: dc_write=1, dc_addr=28'h3F, dc_wdata=128'h1.
  - Response: mem_write=1, mem_wdata=128'h1, dc_ready one pulse, dc_rdata still 0.
- Simultaneous requests after reset:
  - Stimulus: ic_read and dc_read rise together.
  - Response: D served first, then I. With both held continuously, grant order D,I,D,I over 4 transactions.
- Requester withdraws:
  - Stimulus: D read granted, dc_read dropped mid-wait.
  - Response: mem_read held until mem_ready, dc_ready still pulses, arbiter returns to IDLE.
- Reset mid-transaction:
  - Stimulus: rst=1 during I_WAIT.
  - Response: next cycle mem_read=0, ic_ready=0, ic_rdata=0; a late mem_ready afterwards is ignored.
- Spurious ready:
  - Stimulus: mem_ready=1 while IDLE with no requests.
  - Response: no ready pulse and no state change.
